// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Optional colour bars on rgb when VGA_TIMING_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             disp_en,
  output logic             line_end,
  output logic             frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,output logic [11:0]     rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic             le_q, le_d;
  logic             fs_q, fs_d;

  // Next raster position for the coming pixel strobe.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q < H_LAST) begin
      h_d = h_q + ONE;
    end else begin
      h_d = '0;
      if (v_q < V_LAST) begin
        v_d = v_q + ONE;
      end else begin
        v_d = '0;
      end
    end
  end

  // Decode from the next position so registered flags line up with counts.
  always_comb begin
    hs_d = ((h_d >= H_SS) && (h_d < H_SE)) ? HS_ON : ~HS_ON;
    vs_d = ((v_d >= V_SS) && (v_d < V_SE)) ? VS_ON : ~VS_ON;
    de_d = (h_d < H_ACT) && (v_d < V_ACT);
    le_d = (h_d == H_LAST);
    fs_d = (h_d == '0) && (v_d == '0);
  end

  // Counter and decode registers; everything holds between pixel strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= ~HS_ON;
      vs_q <= ~VS_ON;
      de_q <= 1'b0;
      le_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (pix_en) begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      le_q <= le_d;
      fs_q <= fs_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign disp_en     = de_q;
  assign line_end    = le_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_d;
  logic [11:0] rgb_q, rgb_d;

  // Bar index by threshold compares, avoiding a divider.
  always_comb begin
    bar_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_d >= CNT_W'(k * BAR_W)) begin
        bar_d = 3'(k);
      end
    end
  end

  // Bar colour, blanked outside the visible window.
  always_comb begin
    rgb_d = 12'h000;
    if (de_d) begin
      unique case (bar_d)
        3'd0:    rgb_d = 12'hFFF;
        3'd1:    rgb_d = 12'hFF0;
        3'd2:    rgb_d = 12'h0FF;
        3'd3:    rgb_d = 12'h0F0;
        3'd4:    rgb_d = 12'hF0F;
        3'd5:    rgb_d = 12'hF00;
        3'd6:    rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  // Pixel colour register, aligned with disp_en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q <= 12'h000;
    end else if (pix_en) begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Three instances: default 640x480, a tiny raster, and 800x600 positive sync.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic pe    = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [9:0]  h0, v0;
  logic [3:0]  h1, v1;
  logic [10:0] h2, v2;
  logic hs0, vs0, de0, le0, fs0;
  logic hs1, vs1, de1, le1, fs1;
  logic hs2, vs2, de2, le2, fs2;
  logic [11:0] rgb0, rgb1, rgb2;

`ifndef VGA_TIMING_PATTERN_EN
  assign rgb0 = 12'h000;
  assign rgb1 = 12'h000;
  assign rgb2 = 12'h000;
`endif

  vga_timing_gen u0 (
    .clk(clk), .reset(rst_n), .pix_en(pe),
    .h_count(h0), .v_count(v0), .hsync(hs0), .vsync(vs0),
    .disp_en(de0), .line_end(le0), .frame_start(fs0)
`ifdef VGA_TIMING_PATTERN_EN
    , .rgb(rgb0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .CNT_W(4)
  ) u1 (
    .clk(clk), .reset(rst_n), .pix_en(pe),
    .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1),
    .disp_en(de1), .line_end(le1), .frame_start(fs1)
`ifdef VGA_TIMING_PATTERN_EN
    , .rgb(rgb1)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1), .VS_POL(1), .CNT_W(11)
  ) u2 (
    .clk(clk), .reset(rst_n), .pix_en(pe),
    .h_count(h2), .v_count(v2), .hsync(hs2), .vsync(vs2),
    .disp_en(de2), .line_end(le2), .frame_start(fs2)
`ifdef VGA_TIMING_PATTERN_EN
    , .rgb(rgb2)
`endif
  );

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        le;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  int p_ha[3] = '{640, 8, 800};
  int p_hf[3] = '{16, 2, 40};
  int p_hy[3] = '{96, 3, 128};
  int p_hb[3] = '{48, 2, 88};
  int p_va[3] = '{480, 4, 600};
  int p_vf[3] = '{10, 1, 1};
  int p_vy[3] = '{2, 2, 4};
  int p_vb[3] = '{33, 1, 23};
  int p_hp[3] = '{0, 0, 1};
  int p_vp[3] = '{0, 1, 1};
  int cols[8] = '{'hFFF, 'hFF0, 'h0FF, 'h0F0,
                  'hF0F, 'hF00, 'h00F, 'h000};

  int mh[3];
  int mv[3];
  bit madv[3];

  // Reference raster position, one per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mh[i]   <= 0;
        mv[i]   <= 0;
        madv[i] <= 1'b0;
      end else if (pe) begin
        madv[i] <= 1'b1;
        if (mh[i] < p_ha[i] + p_hf[i] + p_hy[i] + p_hb[i] - 1) begin
          mh[i] <= mh[i] + 1;
        end else begin
          mh[i] <= 0;
          if (mv[i] < p_va[i] + p_vf[i] + p_vy[i] + p_vb[i] - 1)
            mv[i] <= mv[i] + 1;
          else
            mv[i] <= 0;
        end
      end
    end
  end

  function automatic obs_t get_obs(int i);
    obs_t o;
    o = '0;
    case (i)
      0: begin
        o.h = 16'(h0); o.v = 16'(v0); o.hs = hs0; o.vs = vs0;
        o.de = de0; o.le = le0; o.fs = fs0; o.rgb = rgb0;
      end
      1: begin
        o.h = 16'(h1); o.v = 16'(v1); o.hs = hs1; o.vs = vs1;
        o.de = de1; o.le = le1; o.fs = fs1; o.rgb = rgb1;
      end
      default: begin
        o.h = 16'(h2); o.v = 16'(v2); o.hs = hs2; o.vs = vs2;
        o.de = de2; o.le = le2; o.fs = fs2; o.rgb = rgb2;
      end
    endcase
    return o;
  endfunction

  function automatic obs_t exp_obs(int i);
    obs_t e;
    int h;
    int v;
    int hss;
    int vss;
    logic hon;
    logic von;
    h   = mh[i];
    v   = mv[i];
    hss = p_ha[i] + p_hf[i];
    vss = p_va[i] + p_vf[i];
    hon = 1'(p_hp[i]);
    von = 1'(p_vp[i]);
    e    = '0;
    e.h  = 16'(h);
    e.v  = 16'(v);
    e.hs = (h >= hss && h < hss + p_hy[i]) ? hon : ~hon;
    e.vs = (v >= vss && v < vss + p_vy[i]) ? von : ~von;
    e.de = madv[i] && h < p_ha[i] && v < p_va[i];
    e.le = (h == hss + p_hy[i] + p_hb[i] - 1);
    e.fs = madv[i] && h == 0 && v == 0;
`ifdef VGA_TIMING_PATTERN_EN
    if (e.de) e.rgb = 12'(cols[h / (p_ha[i] / 8)]);
`endif
    return e;
  endfunction

  task automatic cmp_obs(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b de=%0b le=%0b fs=%0b rgb=%h want h=%0d v=%0d hs=%0b vs=%0b de=%0b le=%0b fs=%0b rgb=%h",
               nm, a.h, a.v, a.hs, a.vs, a.de, a.le, a.fs, a.rgb,
               e.h, e.v, e.hs, e.vs, e.de, e.le, e.fs, e.rgb);
    end
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the reference.
  always @(posedge clk) begin
    #1;
    cmp_obs("mon_d0", get_obs(0), exp_obs(0));
    cmp_obs("mon_d1", get_obs(1), exp_obs(1));
    cmp_obs("mon_d2", get_obs(2), exp_obs(2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int i, int th, int tv, int budget, string nm);
    int n;
    obs_t o;
    n = 0;
    o = get_obs(i);
    while (!(int'(o.h) == th && int'(o.v) == tv) && n < budget) begin
      tick();
      n++;
      o = get_obs(i);
    end
    checks++;
    if (!(int'(o.h) == th && int'(o.v) == tv)) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d want h=%0d v=%0d", nm,
               o.h, o.v, th, tv);
    end
  endtask

  typedef struct {
    bit   rst;
    bit   pe;
    obs_t e;
  } vec_t;

  function automatic vec_t mk(bit r, bit p, int h, int v, bit hs,
                              bit vs, bit de, bit le, bit fs);
    vec_t t;
    t.rst  = r;
    t.pe   = p;
    t.e    = '0;
    t.e.h  = 16'(h);
    t.e.v  = 16'(v);
    t.e.hs = hs;
    t.e.vs = vs;
    t.e.de = de;
    t.e.le = le;
    t.e.fs = fs;
    return t;
  endfunction

  vec_t tbl[9];

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int first_h;
    int last_h;
    int le_h;
    bit prev;
    bit inp;
    obs_t a;

    tbl[0] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[1] = mk(1, 1, 1, 0, 1, 1, 1, 0, 0);
    tbl[2] = mk(1, 0, 1, 0, 1, 1, 1, 0, 0);
    tbl[3] = mk(1, 1, 2, 0, 1, 1, 1, 0, 0);
    tbl[4] = mk(1, 0, 2, 0, 1, 1, 1, 0, 0);
    tbl[5] = mk(1, 1, 3, 0, 1, 1, 1, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[7] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[8] = mk(1, 1, 1, 0, 1, 1, 1, 0, 0);

    rst_n = 1'b0;
    pe    = 1'b1;
    repeat (5) tick();
    chk("rst_d1_vsync_inactive", int'(vs1), 0);
    chk("rst_d2_hsync_inactive", int'(hs2), 0);

    for (int k = 0; k < 9; k++) begin
      rst_n = tbl[k].rst;
      pe    = tbl[k].pe;
      tick();
      a     = get_obs(0);
      a.rgb = '0;
      cmp_obs($sformatf("vec%0d", k), a, tbl[k].e);
    end
    pe = 1'b1;

    // One full default line.
    run_to(0, 0, 1, 900, "reach_line1");
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    first_h = -1; last_h = -1; le_h = -1;
    for (int k = 0; k < 800; k++) begin
      if (!hs0) begin
        cnt_a++;
        if (first_h < 0) first_h = int'(h0);
        last_h = int'(h0);
      end
      if (de0) cnt_b++;
      if (le0) begin
        cnt_c++;
        le_h = int'(h0);
      end
      tick();
    end
    chk("hsync_low_width", cnt_a, 96);
    chk("hsync_first_h", first_h, 656);
    chk("hsync_last_h", last_h, 751);
    chk("disp_en_width", cnt_b, 640);
    chk("line_end_count", cnt_c, 1);
    chk("line_end_h", le_h, 799);
    chk("next_line_h", int'(h0), 0);
    chk("next_line_v", int'(v0), 2);

    // Mid-line reset with pix_en asserted.
    run_to(0, 300, 2, 400, "reach_h300");
    rst_n = 1'b0;
    tick();
    chk("mrst_h", int'(h0), 0);
    chk("mrst_v", int'(v0), 0);
    chk("mrst_hs", int'(hs0), 1);
    chk("mrst_vs", int'(vs0), 1);
    chk("mrst_de", int'(de0), 0);
    chk("mrst_d1_vs", int'(vs1), 0);
    chk("mrst_d2_hs", int'(hs2), 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_resume_h", int'(h0), 1);
    chk("mrst_resume_de", int'(de0), 1);

    // Tiny raster: simultaneous wrap and frame length.
    run_to(1, 14, 7, 200, "reach_last_px");
    chk("last_px_le", int'(le1), 1);
    chk("last_px_fs", int'(fs1), 0);
    tick();
    chk("wrap_h", int'(h1), 0);
    chk("wrap_v", int'(v1), 0);
    chk("wrap_fs", int'(fs1), 1);
    chk("wrap_le", int'(le1), 0);
    n = 0;
    cnt_a = int'(vs1);
    while (n < 500) begin
      tick();
      n++;
      if (fs1) break;
      cnt_a += int'(vs1);
    end
    chk("frame_clocks", n, 120);
    chk("vsync_active_clocks", cnt_a, 30);

    // Alternate pix_en: everything stretches to two clocks per pixel.
    n = 0;
    prev = 1'b1;
    inp = 1'b1;
    cnt_b = 1;
    while (n < 600) begin
      pe = ~pe;
      tick();
      n++;
      if (fs1 && !prev) break;
      if (inp) begin
        if (fs1) cnt_b++;
        else inp = 1'b0;
      end
      prev = fs1;
    end
    chk("gated_frame_clocks", n, 240);
    chk("gated_fs_width", cnt_b, 2);
    pe = 1'b1;

    // 800x600 positive-sync raster.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_to(2, 0, 1, 1200, "reach_sweep_line1");
    cnt_a = 0; first_h = -1; last_h = -1;
    for (int k = 0; k < 1056; k++) begin
      if (hs2) begin
        cnt_a++;
        if (first_h < 0) first_h = int'(h2);
        last_h = int'(h2);
      end
      tick();
    end
    chk("sweep_hs_width", cnt_a, 128);
    chk("sweep_hs_first", first_h, 840);
    chk("sweep_hs_last", last_h, 967);
    chk("sweep_line_v", int'(v2), 2);
    run_to(2, 150, 10, 12000, "reach_150_10");
    chk("sweep_de", int'(de2), 1);
`ifdef VGA_TIMING_PATTERN_EN
    chk("sweep_rgb", int'(rgb2), 'hFF0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
